pwm_capture: RTL

Measures an incoming PWM waveform and reports its period and high time, in `clk` cycles, once per complete period. It is the receive-side counterpart of the PWM generator's timer and period logic, and closes the loop for PWM self-test and external PWM inputs. The block synchronises the asynchronous input, detects edges, and runs a three-state FSM around a saturating cycle counter.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_sync_edge.sv | 66 ++++++
 rtl/pwm_capture.sv | 113 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_t;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILT_LEN    = 3;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises the asynchronous PWM input and produces single-cycle rise/fall strobes.
// With PWM_CAPTURE_GLITCH_FILTER_EN defined, a FILT_LEN-sample majority-free level filter precedes edge detection.
module pwm_sync_edge
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // Plain shift-register synchroniser; the last stage is the usable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [FILT_LEN-2:0] hist_q;
    logic [FILT_LEN-1:0] win;
    logic                filt_q;

    assign win = {hist_q, s};

    // Level follows s only once the whole window agrees, so short pulses and gaps vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= win[FILT_LEN-2:0];
            if (&win) begin
                filt_q <= 1'b1;
            end else if (~|win) begin
                filt_q <= 1'b0;
            end
        end
    end

    assign rise_c = (&win) & ~filt_q;
    assign fall_c = (~|win) & filt_q;
`else
    logic s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise_c = s & ~s_d;
    assign fall_c = ~s & s_d;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clk cycles, reporting once per complete period.
// Optional input glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pwm_in,
    output logic [CNT_BITS-1:0] period,
    output logic [CNT_BITS-1:0] high_time,
    output logic                valid,
    output logic                ovf
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic rise_c;
    logic fall_c;

    pwm_cap_state_t      state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_BITS-1:0] period_d, high_time_d;
    logic                valid_d, ovf_d;
    logic                at_max;

    pwm_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    assign at_max = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_lat_q  <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            period    <= period_d;
            high_time <= high_time_d;
            valid     <= valid_d;
            ovf       <= ovf_d;
        end
    end

    // Next-state and measurement update; a closing rise always beats saturation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        period_d    = period;
        high_time_d = high_time;
        valid_d     = 1'b0;
        ovf_d       = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        cnt_d   = CNT_BITS'(1);
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (fall_c) begin
                        hi_lat_d = cnt_q;
                        cnt_d    = at_max ? cnt_q : cnt_q + 1'b1;
                        state_d  = LOW;
                    end else if (at_max) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LOW: begin
                    if (rise_c) begin
                        period_d    = cnt_q;
                        high_time_d = hi_lat_q;
                        valid_d     = 1'b1;
                        cnt_d       = CNT_BITS'(1);
                        state_d     = HIGH;
                    end else if (at_max) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
